system_sysid_ext: RTL

- Parametrised system-identification slave, the next generation of the fixed two-word sysid.
- Returns a configurable ID, a build timestamp, a capability word, and NUM_USER_WORDS constant user words.
- Adds a byte-writable scratch register, a free-running uptime counter with an atomic 64-bit snapshot, and a pipelined read path with configurable latency.
- Sits on the Avalon-MM system interconnect as a control slave read by host software at boot.

---
 rtl/system_sysid_ext.sv | 138 +++++++++++++
 1 files changed

// File: rtl/system_sysid_ext.sv
// System identification slave: ID, timestamp, capabilities, user words,
// byte-writable scratch, uptime counter with atomic 64-bit snapshot, and a
// fixed-latency pipelined Avalon-MM read path.
module system_sysid_ext #(
  parameter logic [31:0]                  ID_VALUE       = 32'h00C0FFEE,
  parameter logic [31:0]                  TIMESTAMP      = 32'h0,
  parameter int unsigned                  NUM_USER_WORDS = 4,
  parameter logic [32*NUM_USER_WORDS-1:0] USER_WORDS     = '0,
  parameter int unsigned                  READ_LATENCY   = 1,
  parameter int unsigned                  CNT_WIDTH      = 48,
  parameter int unsigned                  ADDR_WIDTH     = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  readdatavalid
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned USER_BASE = 8;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ID      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TS      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CAPS    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SCRATCH = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_UP_LO   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_UP_HI   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CONTROL = ADDR_WIDTH'(6);

  localparam logic [DATA_W-1:0] CAPS = {8'h02, 6'd0, 2'(READ_LATENCY),
                                        8'(CNT_WIDTH), 8'(NUM_USER_WORDS)};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]    scratch_q, scratch_d;
  logic [DATA_W-1:0]    shadow_q, shadow_d;
  logic [DATA_W-1:0]    rdata_c;
  logic                 clear_c;

  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]       data_q [READ_LATENCY];
  logic [DATA_W-1:0]       data_d [READ_LATENCY];

  // Read mux: data chosen from pre-write state at the issue cycle
  always_comb begin
    rdata_c = '0;
    case (address)
      ADDR_ID:      rdata_c = ID_VALUE;
      ADDR_TS:      rdata_c = TIMESTAMP;
      ADDR_CAPS:    rdata_c = CAPS;
      ADDR_SCRATCH: rdata_c = scratch_q;
      ADDR_UP_LO:   rdata_c = cnt_q[DATA_W-1:0];
      ADDR_UP_HI:   rdata_c = shadow_q;
      default: begin
        for (int k = 0; k < NUM_USER_WORDS; k++) begin
          if (address == ADDR_WIDTH'(USER_BASE + k)) begin
            rdata_c = USER_WORDS[DATA_W*k +: DATA_W];
          end
        end
      end
    endcase
  end

  // Uptime counter: free-running, wraps silently, cleared by CONTROL bit0
  always_comb begin
    clear_c = write && (address == ADDR_CONTROL) && byteenable[0] && writedata[0];
    cnt_d   = cnt_q + CNT_WIDTH'(1);
    if (clear_c) begin
      cnt_d = '0;
    end
  end

  // Shadow captures the upper counter bits whenever the low word is read
  always_comb begin
    shadow_d = shadow_q;
    if (read && (address == ADDR_UP_LO)) begin
      shadow_d = DATA_W'(cnt_q >> 32);
    end
  end

  // Scratch register with per-lane byte enables
  always_comb begin
    scratch_d = scratch_q;
    if (write && (address == ADDR_SCRATCH)) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) begin
          scratch_d[8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: stage data only advances with its valid, so the last
  // stage (and readdata) holds its value between responses
  always_comb begin
    vld_d     = '0;
    data_d    = data_q;
    vld_d[0]  = read;
    if (read) begin
      data_d[0] = rdata_c;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      scratch_q <= '0;
      shadow_q  <= '0;
      vld_q     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      shadow_q  <= shadow_d;
      vld_q     <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign readdata      = data_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule
